// File: rtl/mux_8_1.sv
// Registered 8:1 single-bit mux that also captures the select index and its one-hot decode.
// Optional combinational output y_comb is built when MUX8_1_COMB_OUT_EN is defined.
module mux_8_1 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic       i4,
    input  logic       i5,
    input  logic       i6,
    input  logic       i7,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    output logic       y,
    output logic [2:0] sel_q,
    output logic [7:0] sel_onehot
`ifdef MUX8_1_COMB_OUT_EN
    ,
    output logic       y_comb
`endif
);

    logic [2:0] w_idx;
    logic       w_bit;
    logic       w_sel_ok;

    logic       r_y;
    logic [2:0] r_sel;
    logic [7:0] r_onehot;

    assign w_idx = {s1, s2, s3};

    // An X/Z select matches no item, so it lands in default: bit 0, select not valid.
    always_comb begin
        w_bit    = 1'b0;
        w_sel_ok = 1'b1;
        case (w_idx)
            3'd0:    w_bit = i0;
            3'd1:    w_bit = i1;
            3'd2:    w_bit = i2;
            3'd3:    w_bit = i3;
            3'd4:    w_bit = i4;
            3'd5:    w_bit = i5;
            3'd6:    w_bit = i6;
            3'd7:    w_bit = i7;
            default: w_sel_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y      <= 1'b0;
            r_sel    <= 3'd0;
            r_onehot <= 8'h01;
        end else if (en) begin
            r_y <= w_bit;
            if (w_sel_ok) begin
                r_sel    <= w_idx;
                r_onehot <= 8'h01 << w_idx;
            end
        end
    end

    assign y          = r_y;
    assign sel_q      = r_sel;
    assign sel_onehot = r_onehot;

`ifdef MUX8_1_COMB_OUT_EN
    assign y_comb = w_bit;
`endif

endmodule

// File: tb/tb_mux_8_1.sv
// Bench for mux_8_1: array-indexed reference model checked every negedge, plus literal pins.
module tb_mux_8_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] din;
    logic [2:0] sel;
    logic       y;
    logic [2:0] sel_q;
    logic [7:0] sel_onehot;
`ifdef MUX8_1_COMB_OUT_EN
    logic       y_comb;
`endif

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    mux_8_1 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .i0         (din[0]),
        .i1         (din[1]),
        .i2         (din[2]),
        .i3         (din[3]),
        .i4         (din[4]),
        .i5         (din[5]),
        .i6         (din[6]),
        .i7         (din[7]),
        .s1         (sel[2]),
        .s2         (sel[1]),
        .s3         (sel[0]),
        .y          (y),
        .sel_q      (sel_q),
        .sel_onehot (sel_onehot)
`ifdef MUX8_1_COMB_OUT_EN
        ,
        .y_comb     (y_comb)
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the selected bit is simply the array element at the select index.
    logic       exp_y;
    logic [2:0] exp_sel;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_y   <= 1'b0;
            exp_sel <= 3'd0;
        end else if (en) begin
            exp_y   <= din[sel];
            exp_sel <= sel;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic [7:0] oh;
            int ones;
            ones = 0;
            for (int k = 0; k < 8; k++) begin
                oh[k] = (k == int'(exp_sel));
                ones += int'(sel_onehot[k]);
            end
            chk("model_y", {7'd0, y}, {7'd0, exp_y});
            chk("model_sel_q", {5'd0, sel_q}, {5'd0, exp_sel});
            chk("model_onehot", sel_onehot, oh);
            chk("onehot_count", ones[7:0], 8'd1);
`ifdef MUX8_1_COMB_OUT_EN
            chk("model_y_comb", {7'd0, y_comb}, {7'd0, din[sel]});
`endif
        end
    end

    logic [7:0] sweep_y_tab;
    logic [7:0] oh_tab [8];

    initial begin
        sweep_y_tab = 8'b0101_0101;
        oh_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        // Reset held with en=1 and busy inputs.
        rst_n = 1'b0; en = 1'b1; din = 8'hFF; sel = 3'd5;
        #1 check_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_y", {7'd0, y}, 8'd0);
            chk("rst_sel_q", {5'd0, sel_q}, 8'd0);
            chk("rst_onehot", sel_onehot, 8'h01);
        end

        // Full sweep with i0..i7 = 1,0,1,0,1,0,1,0.
        #1 rst_n = 1'b1; din = 8'h55;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            @(negedge clk);
            chk("sweep_y", {7'd0, y}, {7'd0, sweep_y_tab[k]});
            chk("sweep_sel_q", {5'd0, sel_q}, 8'(k));
            chk("sweep_onehot", sel_onehot, oh_tab[k]);
            #1;
        end

        // Hold with en=0.
        sel = 3'd5; din[5] = 1'b1;
        @(negedge clk);
        chk("hold_cap_y", {7'd0, y}, 8'd1);
        #1 en = 1'b0; din[5] = 1'b0; sel = 3'd2;
        repeat (2) begin
            @(negedge clk);
            chk("hold_y", {7'd0, y}, 8'd1);
            chk("hold_sel_q", {5'd0, sel_q}, 8'd5);
            chk("hold_onehot", sel_onehot, 8'h20);
        end
        #1 en = 1'b1;

        // Isolation: i3 fixed at 0, everything else toggling.
        sel = 3'd3; din = 8'h00;
        repeat (6) begin
            @(negedge clk);
            chk("iso_y", {7'd0, y}, 8'd0);
            #1 din = din ^ 8'hF7;
        end

        // Mid-operation asynchronous reset between edges.
        din = 8'h55; sel = 3'd6;
        @(posedge clk);
        #1 chk("pre_rst_y", {7'd0, y}, 8'd1);
        chk("pre_rst_sel_q", {5'd0, sel_q}, 8'd6);
        #1 rst_n = 1'b0;
        #1 chk("midrst_y", {7'd0, y}, 8'd0);
        chk("midrst_sel_q", {5'd0, sel_q}, 8'd0);
        chk("midrst_onehot", sel_onehot, 8'h01);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_y", {7'd0, y}, 8'd1);
        chk("post_rst_sel_q", {5'd0, sel_q}, 8'd6);
        chk("post_rst_onehot", sel_onehot, 8'h40);

`ifdef MUX8_1_COMB_OUT_EN
        // Combinational output follows select between edges; registered y waits.
        #1 sel = 3'd0; din = 8'h01;
        @(negedge clk);
        chk("comb_y0", {7'd0, y}, 8'd1);
        #1 chk("comb_before", {7'd0, y_comb}, 8'd1);
        sel = 3'd4;
        #1 chk("comb_after", {7'd0, y_comb}, 8'd0);
        chk("comb_y_held", {7'd0, y}, 8'd1);
        @(negedge clk);
        chk("comb_y_follow", {7'd0, y}, 8'd0);
        chk("comb_sel_q", {5'd0, sel_q}, 8'd4);
`endif

        // Mixed vectors, checked by the model only.
        repeat (20) begin
            #1 en = 1'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            din = 8'($urandom_range(0, 255));
            @(negedge clk);
        end

        #1 check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_8_1.md
# mux_8_1

Registered 8-to-1 single-bit multiplexer with a 3-bit select split across three scalar select inputs (s1 = MSB, s3 = LSB). It sits in the combinational-primitives library as the clocked variant of the 8:1 mux. It feeds control logic that needs a glitch-free, reset-defined selected bit plus the captured select index. The output updates one clock after the inputs are presented, gated by a capture enable.

## Interface
- No parameters; data width is fixed at 1 bit per input.
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  capture enable; when 1, the selected input and select are registered on the next rising clk
- i0..i7  input  1 each  data inputs; index k selects ik
- s1  input  1  select bit 2 (MSB)
- s2  input  1  select bit 1
- s3  input  1  select bit 0 (LSB)
- y  output  1  registered selected data bit
- sel_q  output  3  registered select index {s1,s2,s3} captured with y
- sel_onehot  output  8  one-hot decode of sel_q; bit k = 1 when sel_q == k
- y_comb  output  1  combinational selected bit; present only with MUX8_1_COMB_OUT_EN

## Operation
- Select index idx = {s1,s2,s3}, giving 000->i0, 001->i1, 010->i2, 011->i3, 100->i4, 101->i5, 110->i6, 111->i7.
- On a rising clk with en = 1: y <= i[idx], sel_q <= idx, sel_onehot <= (8'b1 << idx).
- On a rising clk with en = 0: y, sel_q and sel_onehot hold their values.
- sel_onehot is always exactly one-hot and consistent with sel_q.
- X/Z on any select bit while en = 1 drives y to 0 and leaves sel_q and sel_onehot unchanged. No X propagates into state.
- Unselected data inputs have no effect on any output.

## Timing
- Reset (rst_n = 0, asynchronous assert): y = 0, sel_q = 3'b000, sel_onehot = 8'b0000_0001 immediately, independent of clk.
- Reset release is synchronous to the next rising clk. The first capture occurs on the first rising edge with rst_n = 1 and en = 1.
- Latency is 1 cycle: inputs stable before rising edge N appear on y at edge N.
- Data or select changes between edges with en = 1: only values at the edge are captured.
- Reset asserted mid-operation overrides en and clears all state. Reset deasserted together with en = 1 captures on the next edge.
- y_comb has zero-cycle latency and is unaffected by rst_n or en.

## Configuration
- Macro MUX8_1_COMB_OUT_EN.
  - Defined: port y_comb exists and equals i[{s1,s2,s3}] combinationally (0 on X/Z select).
  - Undefined: y_comb is absent. Registered behaviour is identical in both builds.

## Test plan
- Reset: hold rst_n = 0 with en = 1 and clocks running -> y = 0, sel_q = 000, sel_onehot = 8'h01 throughout. Assert rst_n = 0 between edges -> outputs clear immediately.
- Full sweep: i0..i7 = 1,0,1,0,1,0,1,0, en = 1, step {s1,s2,s3} from 000 to 111, one per clock -> y = 1,0,1,0,1,0,1,0 one cycle later each, with sel_q = 0..7 and sel_onehot = 01,02,04,…,80.
- Hold: capture select 101 with i5 = 1, then en = 0 and change i5 to 0 and select to 010 -> y stays 1, sel_q stays 101.
- Isolation: select 011 with i3 = 0 fixed; toggle all other inputs every cycle -> y stays 0.
- Mid-operation reset: during the sweep, pulse rst_n low for half a cycle at select 110 -> y = 0, sel_q = 000 immediately. The next edge with en = 1 captures i[idx] normally.
- With MUX8_1_COMB_OUT_EN: change select 000->100 between edges with i0 = 1, i4 = 0 -> y_comb goes 1->0 immediately, and y follows at the next edge.
